// File: rtl/paddle_input_ctrl_if.sv
// paddle_input_ctrl_if: paddle controls from input decode and per-channel paddle state toward the game core
interface paddle_input_ctrl_if #(parameter int NCH = 2, parameter int W = 8);
  logic [NCH-1:0]   btn_up;
  logic [NCH-1:0]   btn_down;
  logic [NCH*8-1:0] analog_y;
  logic [NCH*W-1:0] paddle_vpos;
  logic [NCH-1:0]   src_analog;
  logic [NCH-1:0]   moving;
  modport master (output btn_up, btn_down, analog_y, input paddle_vpos, src_analog, moving);
  modport slave (input btn_up, btn_down, analog_y, output paddle_vpos, src_analog, moving);
endinterface

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: per-channel paddle vpos from accelerating digital buttons or analog stick Y
// Optional PADDLE_SMOOTH_EN: analog mode slews toward the target by at most FAST_STEP per tick.
module paddle_input_ctrl #(
  parameter int NCH = 2,
  parameter int W = 8,
  parameter int TICK_DIV = 4,
  parameter int SLOW_STEP = 1,
  parameter int FAST_STEP = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int DEADZONE = 16
) (
  input logic clk_sys,
  input logic reset_n,
  paddle_input_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  logic [PW-1:0] cnt;
  logic tick;
  assign tick = cnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk_sys)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + PW'(1);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t st;
    logic [HW-1:0] hold;
    logic [W-1:0] vpos, tgt, step, dig_v, ana_v, nxt;
    logic [W:0] sum, dif;
    logic [7:0] a, mag;
    logic up, dn, dig, ana, src, src_n, mov;
    assign up = bus.btn_up[i];
    assign dn = bus.btn_down[i];
    assign a = bus.analog_y[8*i +: 8];
    assign mag = a[7] ? 8'(-a) : a;
    assign dig = up ^ dn;
    assign ana = mag > 8'(DEADZONE);
    assign src_n = dig ? 1'b0 : ana ? 1'b1 : src;
    assign tgt = W'({~a[7], a[6:0]}) << (W - 8);
    assign step = st == FAST ? W'(FAST_STEP) : W'(SLOW_STEP);
    assign sum = {1'b0, vpos} + {1'b0, step};
    assign dif = {1'b0, vpos} - {1'b0, step};
    assign dig_v = !dig ? vpos : up ? (dif[W] ? '0 : dif[W-1:0]) : (sum[W] ? '1 : sum[W-1:0]);
`ifdef PADDLE_SMOOTH_EN
    logic [W-1:0] gap;
    assign gap = tgt > vpos ? tgt - vpos : vpos - tgt;
    assign ana_v = gap <= W'(FAST_STEP) ? tgt : tgt > vpos ? vpos + W'(FAST_STEP) : vpos - W'(FAST_STEP);
`else
    assign ana_v = tgt;
`endif
    assign nxt = src_n ? ana_v : dig_v;
    always_ff @(posedge clk_sys)
      if (!reset_n) begin
        vpos <= W'(1) << (W - 1);
        src <= 1'b0;
        mov <= 1'b0;
        st <= IDLE;
        hold <= '0;
      end else if (tick) begin
        vpos <= nxt;
        src <= src_n;
        mov <= nxt != vpos;
        if (src_n || !dig) begin
          st <= IDLE;
          hold <= '0;
        end else if (st == IDLE) begin
          st <= ACCEL_TICKS <= 1 ? FAST : SLOW;
          hold <= HW'(1);
        end else if (st == SLOW) begin
          hold <= hold + HW'(1);
          if (hold + HW'(1) >= HW'(ACCEL_TICKS)) st <= FAST;
        end
      end
    assign bus.paddle_vpos[W*i +: W] = vpos;
    assign bus.src_analog[i] = src;
    assign bus.moving[i] = mov;
  end
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: scoreboard bench for paddle_input_ctrl (NCH=2, W=8)
module tb_paddle_input_ctrl;
  typedef struct packed {
    logic [15:0] vpos;
    logic [1:0]  src;
    logic [1:0]  mov;
  } exp_t;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int mv[2], ms[2], mst[2], mh[2];
  paddle_input_ctrl_if #(.NCH(2), .W(8)) bus ();
  paddle_input_ctrl #(.NCH(2), .W(8), .TICK_DIV(4), .SLOW_STEP(1), .FAST_STEP(4),
                      .ACCEL_TICKS(8), .DEADZONE(16)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
  always #5 clk_sys = ~clk_sys;

  function automatic void model_reset();
    q.delete();
    for (int c = 0; c < 2; c++) begin
      mv[c] = 128; ms[c] = 0; mst[c] = 0; mh[c] = 0;
    end
  endfunction

  function automatic void model_tick(output exp_t e);
    e = '0;
    for (int c = 0; c < 2; c++) begin
      int a, old, nv, tgt, step;
      bit up, dn, dig;
      up = bus.btn_up[c];
      dn = bus.btn_down[c];
      dig = up ^ dn;
      a = int'($signed(bus.analog_y[8*c +: 8]));
      tgt = a + 128;
      old = mv[c];
      nv = old;
      if (dig) ms[c] = 0;
      else if (a > 16 || a < -16) ms[c] = 1;
      if (ms[c] == 1) begin
        mst[c] = 0; mh[c] = 0;
`ifdef PADDLE_SMOOTH_EN
        nv = tgt > old + 4 ? old + 4 : tgt < old - 4 ? old - 4 : tgt;
`else
        nv = tgt;
`endif
      end else if (!dig) begin
        mst[c] = 0; mh[c] = 0;
      end else begin
        step = mst[c] == 2 ? 4 : 1;
        nv = up ? old - step : old + step;
        nv = nv < 0 ? 0 : nv > 255 ? 255 : nv;
        if (mst[c] == 0) begin
          mst[c] = 1; mh[c] = 1;
        end else if (mst[c] == 1) begin
          mh[c] = mh[c] + 1;
          if (mh[c] >= 8) mst[c] = 2;
        end
      end
      mv[c] = nv;
      e.vpos[8*c +: 8] = 8'(nv);
      e.src[c] = ms[c] != 0;
      e.mov[c] = nv != old;
    end
  endfunction

  task automatic tick();
    exp_t e;
    model_tick(e);
    q.push_back(e);
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    bus.btn_up = '0; bus.btn_down = '0; bus.analog_y = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    model_reset();
    checks++;
    if ({bus.paddle_vpos, bus.src_analog, bus.moving} !== 20'h80800) begin
      failures++;
      $display("FAIL reset: got %h want 80800", {bus.paddle_vpos, bus.src_analog, bus.moving});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_accel();
    logic [7:0] seq [10] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h8C, 8'h90};
    exp_t e;
    bus.btn_down = 2'b01;
    for (int n = 0; n < 10; n++) begin
      tick();
      e = q.pop_front();
      checks++;
      if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
        failures++;
        $display("FAIL accel sb tick %0d: got %h want %h", n, {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
      end
      checks++;
      if ({bus.paddle_vpos, bus.moving[0]} !== {8'h80, seq[n], 1'b1}) begin
        failures++;
        $display("FAIL accel tick %0d: got %h/%b want 80%h/1", n, bus.paddle_vpos, bus.moving[0], seq[n]);
      end
    end
    bus.btn_down = 2'b00;
    tick();
    e = q.pop_front();
    checks++;
    if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving} || bus.moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL accel release: got %h want %h", {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] seq [3] = '{8'h01, 8'h00, 8'h00};
    logic [2:0] mseq = 3'b110;
    exp_t e;
    bit hit = 0;
    bus.analog_y = 16'h0082;
    for (int n = 0; n < 40 && !hit; n++) begin
      tick();
      e = q.pop_front();
      checks++;
      if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
        failures++;
        $display("FAIL seek sb tick %0d: got %h want %h", n, {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
      end
      hit = bus.paddle_vpos[7:0] == 8'h02;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL seek timeout: got vpos0 %h want 02", bus.paddle_vpos[7:0]);
    end
    bus.analog_y = '0;
    bus.btn_up = 2'b01;
    for (int n = 0; n < 3; n++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({bus.paddle_vpos[7:0], bus.moving[0], bus.src_analog[0]} !== {seq[n], mseq[2-n], 1'b0}
          || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
        failures++;
        $display("FAIL saturate tick %0d: got %h/%b want %h/%b", n, bus.paddle_vpos[7:0], bus.moving[0], seq[n], mseq[2-n]);
      end
    end
    bus.btn_up = 2'b00;
  endtask

  task automatic test_analog();
    exp_t e;
`ifdef PADDLE_SMOOTH_EN
    logic [7:0] first = 8'h84;
`else
    logic [7:0] first = 8'hC0;
`endif
    bus.analog_y = 16'h4000;
    for (int n = 0; n < 17; n++) begin
      tick();
      e = q.pop_front();
      checks++;
      if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
        failures++;
        $display("FAIL analog sb tick %0d: got %h want %h", n, {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
      end
      if (n == 0) begin
        checks++;
        if ({bus.src_analog[1], bus.paddle_vpos[15:8]} !== {1'b1, first}) begin
          failures++;
          $display("FAIL analog first: got %b/%h want 1/%h", bus.src_analog[1], bus.paddle_vpos[15:8], first);
        end
      end
    end
    checks++;
    if ({bus.paddle_vpos[15:8], bus.moving[1]} !== {8'hC0, 1'b0}) begin
      failures++;
      $display("FAIL analog settle: got %h/%b want c0/0", bus.paddle_vpos[15:8], bus.moving[1]);
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    bus.analog_y = 16'h4008;
    tick();
    e = q.pop_front();
    checks++;
    if ({bus.paddle_vpos[7:0], bus.src_analog[0]} !== 9'h000 || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL deadzone: got %h/%b want 00/0", bus.paddle_vpos[7:0], bus.src_analog[0]);
    end
    bus.btn_down = 2'b01;
    repeat (9) begin
      tick();
      e = q.pop_front();
    end
    checks++;
    if (bus.paddle_vpos[7:0] !== 8'h0C || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL ramp to fast: got %h want 0c", bus.paddle_vpos[7:0]);
    end
    bus.btn_up = 2'b01;
    tick();
    e = q.pop_front();
    checks++;
    if ({bus.paddle_vpos[7:0], bus.moving[0]} !== {8'h0C, 1'b0} || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL both pressed: got %h/%b want 0c/0", bus.paddle_vpos[7:0], bus.moving[0]);
    end
    bus.btn_up = 2'b00;
    tick();
    e = q.pop_front();
    checks++;
    if (bus.paddle_vpos[7:0] !== 8'h0D || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL restart slow: got %h want 0d", bus.paddle_vpos[7:0]);
    end
    bus.btn_down = 2'b10;
    tick();
    e = q.pop_front();
    checks++;
    if ({bus.src_analog[1], bus.paddle_vpos[15:8]} !== {1'b0, 8'hC1} || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL digital wins: got %b/%h want 0/c1", bus.src_analog[1], bus.paddle_vpos[15:8]);
    end
    bus.btn_down = 2'b00;
    bus.analog_y = '0;
  endtask

  task automatic test_reset_midramp();
    exp_t e;
    bus.btn_down = 2'b01;
    repeat (10) begin
      tick();
      e = q.pop_front();
    end
    checks++;
    if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL pre-reset ramp: got %h want %h", {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b0;
    @(posedge clk_sys);
    #1;
    checks++;
    if ({bus.paddle_vpos, bus.src_analog, bus.moving} !== 20'h80800) begin
      failures++;
      $display("FAIL midramp reset: got %h want 80800", {bus.paddle_vpos, bus.src_analog, bus.moving});
    end
    reset_n = 1'b1;
    model_reset();
    model_tick(e);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk_sys);
      #1;
      checks++;
      if (bus.paddle_vpos[7:0] !== 8'h80) begin
        failures++;
        $display("FAIL early tick clk %0d: got %h want 80", n + 1, bus.paddle_vpos[7:0]);
      end
    end
    @(posedge clk_sys);
    #1;
    checks++;
    if (bus.paddle_vpos[7:0] !== 8'h81 || e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
      failures++;
      $display("FAIL first tick after reset: got %h want 81", bus.paddle_vpos[7:0]);
    end
    bus.btn_down = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [10] = '{8'h00, 8'h08, 8'h10, 8'h11, 8'h40, 8'hC0, 8'h80, 8'h7F, 8'hEF, 8'hF0};
    exp_t e;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) bus.btn_up = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.btn_down = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) bus.analog_y = {av[$urandom_range(0, 9)], av[$urandom_range(0, 9)]};
      tick();
      e = q.pop_front();
      checks++;
      if (e !== {bus.paddle_vpos, bus.src_analog, bus.moving}) begin
        failures++;
        $display("FAIL random tick %0d: got %h want %h", n, {bus.paddle_vpos, bus.src_analog, bus.moving}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_saturate();
    test_analog();
    test_conflict();
    test_reset_midramp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
